// File: rtl/pwm_audio_pkg.sv
// ---------------------------------------------------------------------------
// pwm_audio_pkg
// Shared defaults and helpers for the PWM audio output stage.
//   DEF_DATA_W      default sample width (one PWM period = 2**DATA_W cycles)
//   DEF_OVERSAMPLE  default number of PWM periods each sample is held
//   DEF_FIFO_DEPTH  default sample buffer depth (power of two, >= 2)
//   sample_t        sample type at the default width
//   PWM_MAX         largest duty value at the default width
//   rep_width()     width of the period-repeat counter for a given OVERSAMPLE
// ---------------------------------------------------------------------------
package pwm_audio_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_OVERSAMPLE = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic [DEF_DATA_W-1:0] sample_t;

    localparam int PWM_MAX = 2**DEF_DATA_W - 1;

    // A one-period hold still needs a 1-bit counter so the vector is legal.
    function automatic int rep_width(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

endpackage

// File: rtl/pwm_audio_if.sv
// ---------------------------------------------------------------------------
// pwm_audio_if
// Valid/ready sample stream into the PWM audio stage.
//   s_data   unsigned PCM sample
//   s_valid  s_data valid (driven by the producer)
//   s_ready  consumer can accept; a transfer happens when both are high
// Modports: master = sample producer, slave = pwm_audio_out.
// ---------------------------------------------------------------------------
interface pwm_audio_if import pwm_audio_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/pwm_audio_out_sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO buffering PCM samples ahead of the PWM modulator.
//   sysclk, reset  clock and synchronous active-high reset (pointers only)
//   push, wr_data  write strobe and data; caller guarantees !full
//   pop            read strobe; caller guarantees !empty
//   rd_data        head of the queue (valid while !empty)
//   full, empty    occupancy flags
//   level          current occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sample_fifo import pwm_audio_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    // Extra top bit lets full and empty be told apart when the indices match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/pwm_audio_out.sv
// ---------------------------------------------------------------------------
// pwm_audio_out
// Final audio output stage: buffers unsigned PCM samples and turns each one
// into a single-bit PWM stream, holding every sample for OVERSAMPLE periods
// of 2**DATA_W sysclk cycles. The producer is back-pressured to that rate.
//   sysclk      system clock
//   reset       synchronous active-high reset
//   enable      1 = modulate; 0 = output low, counters held at 0
//   s           sample stream (pwm_audio_if.slave: s_data, s_valid, s_ready)
//   pwm_out     registered PWM audio bit
//   underrun    sticky flag: a sample was due while the buffer was empty
//   fifo_level  current buffer occupancy
// ---------------------------------------------------------------------------
module pwm_audio_out import pwm_audio_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        enable,
    pwm_audio_if.slave                  s,
    output logic                        pwm_out,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int               REP_W    = rep_width(OVERSAMPLE);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(OVERSAMPLE - 1);

    logic [DATA_W-1:0] cnt_p0;
    logic [REP_W-1:0]  rep_p0;
    logic [DATA_W-1:0] duty_p0;
    logic [DATA_W-1:0] head;
    logic              pwm_p1;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              boundary;

    assign s.s_ready = !full && !reset;
    assign push      = s.s_valid && s.s_ready;

    // Last cycle of the last repeated period: next sample is due on this edge.
    assign boundary  = enable && (cnt_p0 == '1) && (rep_p0 == REP_LAST);
    assign pop       = boundary && !empty;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (s.s_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // ---- stage p0: period counter, repeat counter, duty load ----
    // ---- stage p1: registered comparator output ----
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_p0   <= '0;
            rep_p0   <= '0;
            duty_p0  <= '0;
            pwm_p1   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            pwm_p1 <= enable && (cnt_p0 < duty_p0);

            if (!enable) begin
                cnt_p0 <= '0;
                rep_p0 <= '0;
            end else begin
                cnt_p0 <= cnt_p0 + DATA_W'(1);
                if (cnt_p0 == '1)
                    rep_p0 <= (rep_p0 == REP_LAST) ? '0 : rep_p0 + REP_W'(1);
            end

            // The counter wraps to 0 on this same edge, so the new duty
            // governs the whole of the next period.
            if (pop)
                duty_p0 <= head;
            if (boundary && empty)
                underrun <= 1'b1;
        end
    end

    assign pwm_out = pwm_p1;

endmodule

// File: tb/tb_pwm_audio_out.sv
// ---------------------------------------------------------------------------
// tb_pwm_audio_out
// Bench for pwm_audio_out: one instance with OVERSAMPLE=1 and one with
// OVERSAMPLE=4 share the same stimulus. A behavioural model (a single
// position-in-hold counter plus a sample queue per instance) predicts every
// output after each clock edge; directed sections add hand-computed checks.
// ---------------------------------------------------------------------------
module tb_pwm_audio_out;
    import pwm_audio_pkg::*;

    localparam int DEPTH = 4;
    localparam int OS1   = 4;
    localparam int PER   = PWM_MAX + 1;

    logic    sysclk  = 1'b0;
    logic    reset   = 1'b1;
    logic    enable  = 1'b0;
    logic    s_valid = 1'b0;
    sample_t s_data  = '0;

    logic       pwm0, pwm1, und0, und1;
    logic [2:0] lvl0, lvl1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    pwm_audio_if #(.DATA_W(8)) ifc0();
    pwm_audio_if #(.DATA_W(8)) ifc1();

    assign ifc0.s_valid = s_valid;
    assign ifc0.s_data  = s_data;
    assign ifc1.s_valid = s_valid;
    assign ifc1.s_data  = s_data;

    pwm_audio_out #(.DATA_W(8), .OVERSAMPLE(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .sysclk(sysclk), .reset(reset), .enable(enable), .s(ifc0),
        .pwm_out(pwm0), .underrun(und0), .fifo_level(lvl0));

    pwm_audio_out #(.DATA_W(8), .OVERSAMPLE(OS1), .FIFO_DEPTH(DEPTH)) dut1 (
        .sysclk(sysclk), .reset(reset), .enable(enable), .s(ifc1),
        .pwm_out(pwm1), .underrun(und1), .fifo_level(lvl1));

    always #5 sysclk = ~sysclk;

    // ---------------- reference model ----------------
    int mq0[$];
    int mq1[$];
    int mt[2];      // position inside the current hold (0 .. PER*OS-1)
    int mduty[2];
    bit mpwm[2];
    bit mund[2];
    int mos[2] = '{1, OS1};

    function automatic int msize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic model_step(input int k);
        int hold;
        bit rdy;
        hold = PER * mos[k];
        if (reset) begin
            mt[k] = 0; mduty[k] = 0; mpwm[k] = 0; mund[k] = 0;
            if (k == 0) mq0.delete(); else mq1.delete();
        end else begin
            rdy     = msize(k) < DEPTH;
            mpwm[k] = enable && ((mt[k] % PER) < mduty[k]);
            if (enable && mt[k] == hold - 1) begin
                if (msize(k) > 0) begin
                    if (k == 0) mduty[k] = mq0.pop_front();
                    else        mduty[k] = mq1.pop_front();
                end else begin
                    mund[k] = 1;
                end
            end
            if (s_valid && rdy) begin
                if (k == 0) mq0.push_back(int'(s_data));
                else        mq1.push_back(int'(s_data));
            end
            mt[k] = enable ? (mt[k] + 1) % hold : 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge sysclk);
        #1;
        cyc++;
        check("pwm0",   int'(pwm0), int'(mpwm[0]));
        check("und0",   int'(und0), int'(mund[0]));
        check("lvl0",   int'(lvl0), msize(0));
        check("ready0", int'(ifc0.s_ready), int'(!reset && msize(0) < DEPTH));
        check("pwm1",   int'(pwm1), int'(mpwm[1]));
        check("und1",   int'(und1), int'(mund[1]));
        check("lvl1",   int'(lvl1), msize(1));
        check("ready1", int'(ifc1.s_ready), int'(!reset && msize(1) < DEPTH));
    endtask

    task automatic run_until(input int k, input int target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mt[k] != target && n < 5000);
        if (mt[k] != target) check("run_until_timeout", n, -1);
    endtask

    task automatic count_high(input int k, input int n, output int hi, output int first);
        hi = 0;
        first = 0;
        for (int j = 0; j < n; j++) begin
            tick();
            if (j == 0) first = (k == 0) ? int'(pwm0) : int'(pwm1);
            hi += (k == 0) ? int'(pwm0) : int'(pwm1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        sample_t sample;
        int      exp_high;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int hi, first, lv;

        tbl[0] = '{8'd64,  64};
        tbl[1] = '{8'd0,   0};
        tbl[2] = '{8'd255, 255};
        tbl[3] = '{8'd1,   1};
        tbl[4] = '{8'd128, 128};
        tbl[5] = '{8'd200, 200};

        // Reset state
        tick();
        tick();
        check("rst_pwm",   int'(pwm0), 0);
        check("rst_lvl",   int'(lvl0), 0);
        check("rst_und",   int'(und0), 0);
        check("rst_ready", int'(ifc0.s_ready), 0);

        // Release, push 64 at cnt=0: silent first period
        reset = 1'b0; enable = 1'b1;
        #1;
        check("rel_ready", int'(ifc0.s_ready), 1);
        s_valid = 1'b1; s_data = tbl[0].sample;
        tick();
        s_valid = 1'b0;
        count_high(0, PER - 1, hi, first);
        check("first_period_high", hi, 0);

        // Table: each sample plays one full period; next one pushed at its start
        for (int i = 0; i < 6; i++) begin
            hi = 0;
            for (int j = 0; j < PER; j++) begin
                if (j == 0 && i < 5) begin
                    s_valid = 1'b1; s_data = tbl[i+1].sample;
                end else begin
                    s_valid = 1'b0;
                end
                tick();
                if (j == 0) check("vec_first_bit", int'(pwm0), int'(tbl[i].sample != 0));
                if (j == PER - 2) check("vec_no_underrun", int'(und0), 0);
                hi += int'(pwm0);
            end
            check("vec_high_count", hi, tbl[i].exp_high);
        end
        s_valid = 1'b0;

        // Buffer ran dry at the last boundary: sticky flag, duty repeats
        check("underrun_set", int'(und0), 1);
        count_high(0, PER, hi, first);
        check("duty_repeat", hi, 200);
        s_valid = 1'b1; s_data = 8'd10;
        tick();
        s_valid = 1'b0;
        tick();
        check("underrun_sticky", int'(und0), 1);

        // Back-pressure with s_valid held high
        do_reset();
        check("reset_clears_und", int'(und0), 0);
        s_valid = 1'b1; s_data = sample_t'($urandom);
        for (int i = 0; i < 6; i++) tick();
        check("bp_full_lvl",   int'(lvl0), 4);
        check("bp_full_ready", int'(ifc0.s_ready), 0);
        enable = 1'b1;
        run_until(0, 0);
        check("bp_pop_lvl",   int'(lvl0), 3);
        check("bp_pop_ready", int'(ifc0.s_ready), 1);
        tick();
        check("bp_refill_lvl",   int'(lvl0), 4);
        check("bp_refill_ready", int'(ifc0.s_ready), 0);
        tick();
        check("bp_one_more_only", int'(lvl0), 4);
        s_valid = 1'b0;

        // OVERSAMPLE=4 instance: 128 then 32, each held 4 periods
        do_reset();
        enable = 1'b1;
        s_valid = 1'b1; s_data = 8'd128;
        tick();
        s_data = 8'd32;
        tick();
        s_valid = 1'b0;
        run_until(1, 0);
        count_high(1, PER * OS1, hi, first);
        check("os4_hold_128", hi, 128 * OS1);
        count_high(1, PER * OS1, hi, first);
        check("os4_hold_32", hi, 32 * OS1);

        // Enable dropped at cnt=100, restart from cnt=0
        do_reset();
        enable = 1'b1;
        s_valid = 1'b1; s_data = 8'd200;
        tick();
        s_valid = 1'b0;
        run_until(0, 0);
        run_until(0, 100);
        lv = int'(lvl0);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("dis_pwm_low", int'(pwm0), 0);
            check("dis_lvl_hold", int'(lvl0), lv);
        end
        enable = 1'b1;
        tick();
        check("reen_first_high", int'(pwm0), 1);
        count_high(0, PER - 1, hi, first);
        check("reen_rest_high", hi, 199);

        // Reset mid-period with three samples buffered
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = sample_t'($urandom);
            tick();
        end
        s_valid = 1'b0;
        enable = 1'b1;
        run_until(0, 50);
        check("mid_lvl_before", int'(lvl0), 3);
        reset = 1'b1;
        tick();
        check("mid_rst_lvl",   int'(lvl0), 0);
        check("mid_rst_pwm",   int'(pwm0), 0);
        check("mid_rst_ready", int'(ifc0.s_ready), 0);
        reset = 1'b0;
        tick();
        check("mid_rel_ready", int'(ifc0.s_ready), 1);
        check("mid_rel_lvl",   int'(lvl0), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 6000; i++) begin
            reset   = ($urandom_range(0, 599) == 0);
            enable  = ($urandom_range(0, 19) != 0);
            s_valid = (i < 3000) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 199) < 2);
            s_data  = sample_t'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
Final audio output stage. Accepts unsigned PCM samples over a valid/ready handshake, buffers them in a small FIFO, and converts each sample to a single-bit PWM stream for one board audio pin (pwm_aud*). One instance drives each audio output pin. Samples are consumed at a fixed rate of one per OVERSAMPLE PWM periods, so the upstream tone or sample generator is back-pressured to the audio rate.

Parameters:
DATA_W, 8, sample width; one PWM period is 2**DATA_W sysclk cycles.
OVERSAMPLE, 1, number of PWM periods each sample is held (>=1).
FIFO_DEPTH, 4, sample buffer entries (power of two, >=2).

Ports:
sysclk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = modulate; 0 = output held low, counters frozen at 0
s_data  input  DATA_W  unsigned sample, 0 = silence/min, 2**DATA_W-1 = max
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept; transfer when s_valid && s_ready
pwm_out  output  1  PWM audio bit
underrun  output  1  sticky; set when a sample is needed and the FIFO is empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): cnt=0, rep=0, duty=0, FIFO empty, pwm_out=0, underrun=0, fifo_level=0. s_ready=0 while reset is high, and rises the cycle after reset deasserts.
- s_ready = !full && !reset (combinational). A push happens on a rising edge with s_valid && s_ready. fifo_level updates on the same edge.
- PWM counter: cnt is DATA_W bits and increments each cycle while enable=1. It wraps from 2**DATA_W-1 to 0. rep counts wraps from 0 to OVERSAMPLE-1, then back to 0.
- Output: pwm_out is registered, pwm_out(t+1) = enable(t) && (cnt(t) < duty(t)).
  - duty=0 gives a constant low.
  - duty=2**DATA_W-1 gives high for 2**DATA_W-1 of 2**DATA_W cycles.
- Sample load: on the edge where cnt==2**DATA_W-1 and rep==OVERSAMPLE-1 (the period boundary):
  - FIFO non-empty: pop the head into duty. The new duty takes effect from the next cnt=0.
  - FIFO empty: duty holds its last value and underrun sets to 1. underrun clears only on reset.
- Simultaneous push and pop:
  - On a non-full FIFO, both occur and fifo_level is unchanged.
  - When the FIFO is empty at the boundary, the pop sees empty: underrun sets and the pushed sample is stored for the next boundary.
  - When the FIFO is full, s_ready=0, so no push; a pop frees a slot and s_ready=1 the next cycle.
- enable=0:
  - cnt and rep are held at 0, no pops occur, and pwm_out goes 0 one cycle later.
  - The FIFO still accepts pushes.
  - When enable returns to 1, counting restarts from cnt=0 with the current duty.
- First sample after reset: duty=0 until the first boundary, so the first sample is audible in the second PWM period. This is the required latency: 2**DATA_W*OVERSAMPLE cycles from cnt=0.
- Reset mid-period: everything returns to reset values on the next edge, and FIFO contents are discarded.
- Arithmetic: cnt is unsigned and wraps; the comparison is unsigned DATA_W-bit; pointers are log2(FIFO_DEPTH) bits plus a wrap bit.

Decomposition:
- Package pwm_audio_pkg:
  - parameter defaults (DATA_W=8, OVERSAMPLE=1, FIFO_DEPTH=4)
  - typedef sample_t = logic [DATA_W-1:0]
  - localparam PWM_MAX = 2**DATA_W-1
- Sub-module sample_fifo:
  - synchronous FIFO with sysclk/reset, push/pop, full/empty, level
  - no read-during-empty: the pop is qualified by !empty in the parent
- PWM counter, comparator and load logic live in pwm_audio_out.

Test Plan:
- Reset, then push 64 at cnt=0 (DATA_W=8, OVERSAMPLE=1). Required response:
  - pwm_out=0 for the first 256 cycles;
  - then exactly 64 high cycles per 256-cycle period, high one cycle after cnt=0, for every following period;
  - underrun stays 0 if refilled, otherwise sets at the next boundary.
- Push 0 then 255. Required response:
  - period with 0: zero high cycles;
  - period with 255: 255 high cycles and 1 low cycle.
- Hold s_valid=1 with no reset afterwards. Required response:
  - s_ready drops after 4 accepted pushes, with fifo_level=4;
  - at each boundary fifo_level goes to 3 and s_ready rises the next cycle;
  - exactly one more sample is accepted.
- Stop pushing after one sample. Required response:
  - at the second boundary underrun=1 and the duty is repeated;
  - a later push does not clear underrun, and only reset clears it.
- Set OVERSAMPLE=4 and push 128,32. Required response:
  - 128 is held for 4 periods (1024 cycles) with 128 high per period, then 32 is held for 4 periods.
- Drop enable mid-period at cnt=100. Required response:
  - pwm_out=0 from the next cycle and fifo_level constant;
  - on re-enable, the period restarts at cnt=0.
- Assert reset at cnt=50 with fifo_level=3. Required response:
  - next edge: fifo_level=0, pwm_out=0, s_ready=0;
  - s_ready=1 one cycle after release.
